// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard port bundle: two read ports, one writeback
// port and one claim port. The master side is issue/writeback logic, the
// slave side is the register file itself.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [XLEN-1:0] Read_Data1;
  logic [XLEN-1:0] Read_Data2;
  logic            Busy1;
  logic            Busy2;
  logic            Write_Enable3;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] Write_Data3;
  logic            Claim_En;
  logic [AW-1:0]   Claim_Addr;
  logic [AW:0]     Busy_Count;
  logic            Reclaim_Err;

  modport master (
    output A1, A2, Write_Enable3, A3, Write_Data3, Claim_En, Claim_Addr,
    input  Read_Data1, Read_Data2, Busy1, Busy2, Busy_Count, Reclaim_Err
  );

  modport slave (
    input  A1, A2, Write_Enable3, A3, Write_Data3, Claim_En, Claim_Addr,
    output Read_Data1, Read_Data2, Busy1, Busy2, Busy_Count, Reclaim_Err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREGS x XLEN register file with a per-register busy
// scoreboard, a running busy count and a sticky reclaim error flag.
// Register 0 is hardwired to zero and can never be claimed.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a same-cycle
// writeback to a read address is forwarded to that read port (data and busy).
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

  logic [XLEN-1:0]  data_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [AW:0]      busy_count_r;
  logic             reclaim_err_r;

  logic             wr_hit_s;
  logic             cl_hit_s;
  logic             inc_s;
  logic             dec_s;
  logic [AW:0]      busy_count_next_s;
  logic [XLEN-1:0]  rd1_s;
  logic [XLEN-1:0]  rd2_s;
  logic             busy1_s;
  logic             busy2_s;

  // Read one port: register 0 is always zero/not busy; optional writeback forwarding.
  function automatic logic [XLEN:0] read_port(input logic [AW-1:0] addr,
                                               input logic          wr_hit,
                                               input logic          cl_hit);
    logic [XLEN:0] res;
    res = {(XLEN+1){1'b0}};
    if (addr == ZERO_ADDR) begin
      res = {(XLEN+1){1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_hit && (bus.A3 == addr)) begin
      res = {(cl_hit && (bus.Claim_Addr == addr)), bus.Write_Data3};
    end
`endif
    else begin
      res = {busy_r[addr], data_r[addr]};
    end
    return res;
  endfunction

  // Qualify strobes and work out the busy-count delta from old vs final bit values.
  always_comb begin
    wr_hit_s = bus.Write_Enable3 && (bus.A3 != ZERO_ADDR);
    cl_hit_s = bus.Claim_En && (bus.Claim_Addr != ZERO_ADDR);
    inc_s    = cl_hit_s && !busy_r[bus.Claim_Addr];
    // A write only clears the bit if a same-cycle claim to it does not win.
    dec_s    = wr_hit_s && busy_r[bus.A3] &&
               !(cl_hit_s && (bus.Claim_Addr == bus.A3));
    busy_count_next_s = busy_count_r + (AW+1)'(inc_s) - (AW+1)'(dec_s);
  end

  // Read ports, held at zero while reset is asserted.
  always_comb begin
    {busy1_s, rd1_s} = {(XLEN+1){1'b0}};
    {busy2_s, rd2_s} = {(XLEN+1){1'b0}};
    if (reset) begin
      {busy1_s, rd1_s} = read_port(bus.A1, wr_hit_s, cl_hit_s);
      {busy2_s, rd2_s} = read_port(bus.A2, wr_hit_s, cl_hit_s);
    end else begin
      {busy1_s, rd1_s} = {(XLEN+1){1'b0}};
      {busy2_s, rd2_s} = {(XLEN+1){1'b0}};
    end
  end

  // Data array, busy bits, busy count and sticky reclaim error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        data_r[i] <= {XLEN{1'b0}};
      end
      busy_r        <= {NREGS{1'b0}};
      busy_count_r  <= {(AW+1){1'b0}};
      reclaim_err_r <= 1'b0;
    end else begin
      if (wr_hit_s) begin
        data_r[bus.A3] <= bus.Write_Data3;
      end
      // Claim is applied after the write clear so it wins on a shared address.
      for (int i = 1; i < NREGS; i++) begin
        if (cl_hit_s && (bus.Claim_Addr == AW'(i))) begin
          busy_r[i] <= 1'b1;
        end else if (wr_hit_s && (bus.A3 == AW'(i))) begin
          busy_r[i] <= 1'b0;
        end else begin
          busy_r[i] <= busy_r[i];
        end
      end
      busy_r[0]    <= 1'b0;
      busy_count_r <= busy_count_next_s;
      if (cl_hit_s && busy_r[bus.Claim_Addr]) begin
        reclaim_err_r <= 1'b1;
      end else begin
        reclaim_err_r <= reclaim_err_r;
      end
    end
  end

  assign bus.Read_Data1  = rd1_s;
  assign bus.Read_Data2  = rd2_s;
  assign bus.Busy1       = busy1_s;
  assign bus.Busy2       = busy2_s;
  assign bus.Busy_Count  = busy_count_r;
  assign bus.Reclaim_Err = reclaim_err_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default 32x32 file).
// Expected values are hand-computed; bypass-dependent ones follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .AW(5)) bus ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are then changed 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Write_Enable3 = 1'b0;
    bus.A3            = 5'd0;
    bus.Write_Data3   = 32'h0;
    bus.Claim_En      = 1'b0;
    bus.Claim_Addr    = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.A1 = 5'd5;
    bus.A2 = 5'd0;
    tick();
    tick();
    #1;
    checks++; if (bus.Busy_Count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.Busy_Count); end
    checks++; if (bus.Reclaim_Err !== 1'b0) begin errors++; $display("FAIL reset_reclaim got=%0b exp=0", bus.Reclaim_Err); end
    checks++; if (bus.Read_Data1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", bus.Read_Data1); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_write_basic();
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd5; bus.Write_Data3 = 32'hDEADBEEF;
    tick();
    bus.A3 = 5'd0; bus.Write_Data3 = 32'h12345678;
    tick();
    idle_inputs();
    bus.A1 = 5'd5; bus.A2 = 5'd0;
    #1;
    checks++; if (bus.Read_Data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_r5 got=%h exp=deadbeef", bus.Read_Data1); end
    checks++; if (bus.Read_Data2 !== 32'h0) begin errors++; $display("FAIL wr_r0 got=%h exp=0", bus.Read_Data2); end
    checks++; if (bus.Busy2 !== 1'b0) begin errors++; $display("FAIL wr_r0_busy got=%b exp=0", bus.Busy2); end
    checks++; if (bus.Busy_Count !== 6'd0) begin errors++; $display("FAIL wr_count got=%0d exp=0", bus.Busy_Count); end
  endtask

  task automatic test_claims();
    logic [4:0] regs [3];
    regs[0] = 5'd3; regs[1] = 5'd7; regs[2] = 5'd9;
    for (int i = 0; i < 3; i++) begin
      bus.Claim_En = 1'b1; bus.Claim_Addr = regs[i];
      tick();
      checks++; if (bus.Busy_Count !== 6'(i + 1)) begin errors++; $display("FAIL claim_count%0d got=%0d exp=%0d", i, bus.Busy_Count, i + 1); end
    end
    idle_inputs();
    bus.A1 = 5'd7;
    #1;
    checks++; if (bus.Busy1 !== 1'b1) begin errors++; $display("FAIL claim_busy7 got=%b exp=1", bus.Busy1); end
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd7; bus.Write_Data3 = 32'h00000077;
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.Busy_Count !== 6'd2) begin errors++; $display("FAIL wb7_count got=%0d exp=2", bus.Busy_Count); end
    checks++; if (bus.Busy1 !== 1'b0) begin errors++; $display("FAIL wb7_busy got=%b exp=0", bus.Busy1); end
    checks++; if (bus.Reclaim_Err !== 1'b0) begin errors++; $display("FAIL wb7_reclaim got=%b exp=0", bus.Reclaim_Err); end
    checks++; if (bus.Read_Data1 !== 32'h00000077) begin errors++; $display("FAIL wb7_data got=%h exp=77", bus.Read_Data1); end
  endtask

  task automatic test_claim_write_diff();
    // Busy now: 3, 9. Make 4 busy too.
    bus.Claim_En = 1'b1; bus.Claim_Addr = 5'd4;
    tick();
    checks++; if (bus.Busy_Count !== 6'd3) begin errors++; $display("FAIL pre4_count got=%0d exp=3", bus.Busy_Count); end
    // Reclaim 4 while writing 9: +0 -1 ... 4 already busy so only 9 clears.
    bus.Claim_Addr = 5'd4;
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd9; bus.Write_Data3 = 32'h99;
    tick();
    idle_inputs();
    bus.A1 = 5'd4; bus.A2 = 5'd9;
    #1;
    checks++; if (bus.Busy_Count !== 6'd2) begin errors++; $display("FAIL cw_count got=%0d exp=2", bus.Busy_Count); end
    checks++; if (bus.Busy1 !== 1'b1) begin errors++; $display("FAIL cw_busy4 got=%b exp=1", bus.Busy1); end
    checks++; if (bus.Busy2 !== 1'b0) begin errors++; $display("FAIL cw_busy9 got=%b exp=0", bus.Busy2); end
    checks++; if (bus.Reclaim_Err !== 1'b1) begin errors++; $display("FAIL cw_reclaim got=%b exp=1", bus.Reclaim_Err); end
    // Claim 4 again, then idle; the flag must stay set and the count not move.
    bus.Claim_En = 1'b1; bus.Claim_Addr = 5'd4;
    tick();
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.Reclaim_Err !== 1'b1) begin errors++; $display("FAIL reclaim_sticky got=%b exp=1", bus.Reclaim_Err); end
    checks++; if (bus.Busy_Count !== 6'd2) begin errors++; $display("FAIL reclaim_count got=%0d exp=2", bus.Busy_Count); end
    // Claim and write to register 0 are ignored.
    bus.Claim_En = 1'b1; bus.Claim_Addr = 5'd0;
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd0; bus.Write_Data3 = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    bus.A1 = 5'd0;
    #1;
    checks++; if (bus.Busy_Count !== 6'd2) begin errors++; $display("FAIL r0_count got=%0d exp=2", bus.Busy_Count); end
    checks++; if ({bus.Busy1, bus.Read_Data1} !== 33'h0) begin errors++; $display("FAIL r0_read got=%b/%h exp=0/0", bus.Busy1, bus.Read_Data1); end
  endtask

  task automatic test_same_reg();
    // Busy: 3, 4. Claim+write 6 together.
    bus.Claim_En = 1'b1; bus.Claim_Addr = 5'd6;
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd6; bus.Write_Data3 = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    bus.A1 = 5'd6;
    #1;
    checks++; if (bus.Read_Data1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL same6_data got=%h exp=a5a5a5a5", bus.Read_Data1); end
    checks++; if (bus.Busy1 !== 1'b1) begin errors++; $display("FAIL same6_busy got=%b exp=1", bus.Busy1); end
    checks++; if (bus.Busy_Count !== 6'd3) begin errors++; $display("FAIL same6_count got=%0d exp=3", bus.Busy_Count); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
    logic        exp_b;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'h00000042;
    exp_b = 1'b0;
`else
    exp_d = 32'h00000000;
    exp_b = 1'b1;
`endif
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd10; bus.Write_Data3 = 32'h00000042;
    bus.A1 = 5'd10;
    #1;
    checks++; if (bus.Read_Data1 !== exp_d) begin errors++; $display("FAIL byp10_same got=%h exp=%h", bus.Read_Data1, exp_d); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.Read_Data1 !== 32'h00000042) begin errors++; $display("FAIL byp10_next got=%h exp=42", bus.Read_Data1); end
    // Writeback to busy register 6 read on port 2 in the same cycle.
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd6; bus.Write_Data3 = 32'h66;
    bus.A2 = 5'd6;
    #1;
    checks++; if (bus.Busy2 !== exp_b) begin errors++; $display("FAIL byp6_busy got=%b exp=%b", bus.Busy2, exp_b); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.Busy2 !== 1'b0) begin errors++; $display("FAIL wb6_busy got=%b exp=0", bus.Busy2); end
    checks++; if (bus.Busy_Count !== 6'd2) begin errors++; $display("FAIL wb6_count got=%0d exp=2", bus.Busy_Count); end
  endtask

  task automatic test_reset_mid();
    // Busy: 3, 4. Add 12 to reach three busy.
    bus.Claim_En = 1'b1; bus.Claim_Addr = 5'd12;
    tick();
    checks++; if (bus.Busy_Count !== 6'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", bus.Busy_Count); end
    bus.Claim_En = 1'b0;
    bus.Write_Enable3 = 1'b1; bus.A3 = 5'd5; bus.Write_Data3 = 32'hFFFF0000;
    bus.A1 = 5'd5; bus.A2 = 5'd3;
    reset = 1'b0;
    #1;
    checks++; if (bus.Busy_Count !== 6'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", bus.Busy_Count); end
    checks++; if (bus.Reclaim_Err !== 1'b0) begin errors++; $display("FAIL mid_reclaim got=%b exp=0", bus.Reclaim_Err); end
    checks++; if ({bus.Busy1, bus.Read_Data1, bus.Busy2, bus.Read_Data2} !== 66'h0) begin errors++; $display("FAIL mid_reads got=%h/%h exp=0/0", bus.Read_Data1, bus.Read_Data2); end
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    #1;
    for (int r = 0; r < 32; r++) begin
      bus.A1 = 5'(r);
      #1;
      checks++; if ({bus.Busy1, bus.Read_Data1} !== 33'h0) begin errors++; $display("FAIL post_rst_r%0d got=%b/%h exp=0/0", r, bus.Busy1, bus.Read_Data1); end
    end
    checks++; if (bus.Busy_Count !== 6'd0) begin errors++; $display("FAIL post_rst_count got=%0d exp=0", bus.Busy_Count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.A1 = 5'd0;
    bus.A2 = 5'd0;
    idle_inputs();
    test_reset();
    test_write_basic();
    test_claims();
    test_claim_write_diff();
    test_same_reg();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
